pushbutton_conditioner: RTL and testbench

Input-side conditioner sitting directly upstream of the processor's 4-bit pushbuttons input, which the IN path places onto data_bus. Per button, it synchronises the raw pad, debounces it with a counter and produces a clean level. It also records press events in sticky flags that are cleared when the processor reads the port, so short presses between reads are not lost.

---
 rtl/up_pkg.sv | 20 ++
 rtl/debounce_bit.sv | 54 +++++
 rtl/pushbutton_conditioner.sv | 62 ++++++
 tb/tb_pushbutton_conditioner.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared constants and sizing helper for processor peripheral blocks
//   N_BTN_DEF : default pushbutton count, matches the 4-bit data bus
//   clog2()   : ceiling log2, used to size counters
package up_pkg;

  localparam int N_BTN_DEF = 4;

  // Smallest w with 2**w >= value; returns 0 for value <= 1.
  function automatic int clog2(input longint value);
    int w;
    w = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'sd1 <<< i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser, debounce counter and level register for one button
//   clock  : system clock
//   reset  : synchronous, active-high
//   raw    : asynchronous, bouncing pad input
//   level  : debounced level
//   rise   : high in the cycle whose edge will take level from 0 to 1
module debounce_bit
  import up_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W_RAW = clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The new level is accepted on the edge where the count is already at its
  // maximum and s2 still disagrees, so the counter never exceeds CNT_MAX.
  assign accept = (s2 != level) && (cnt == CNT_MAX);
  assign rise   = accept && s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        // Any glitch back to the current level restarts qualification.
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - debounced pushbutton port with sticky press/overrun flags
//   clock       : system clock, shared with the processor
//   reset       : synchronous, active-high
//   btn_raw     : raw pad inputs, active-high
//   rd_strobe   : processor read of the port; clears event and overrun flags
//   btn_level   : debounced levels
//   btn_event   : sticky debounced rising-edge flags
//   overrun     : sticky flag, press arrived while the event was still unread
//   pushbuttons : value presented to the processor (events or levels)
module pushbutton_conditioner
  import up_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STICKY          = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             rd_strobe,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_event,
  output logic [N_BTN-1:0] overrun,
  output logic [N_BTN-1:0] pushbuttons
);

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] rd_mask;

  assign rd_mask = {N_BTN{rd_strobe}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  // A rise coinciding with a read sets the event (the read consumed the old
  // one) and is not an overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_event <= '0;
      overrun   <= '0;
    end else begin
      btn_event <= rise | (btn_event & ~rd_mask);
      overrun   <= (rise & btn_event & ~rd_mask) | (overrun & ~rd_mask);
    end
  end

  if (STICKY != 0) begin : g_sticky
    assign pushbuttons = btn_event;
  end else begin : g_level
    assign pushbuttons = btn_level;
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - directed vector bench for pushbutton_conditioner
module tb_pushbutton_conditioner;

  logic       clock;
  logic       reset;
  logic [3:0] btn_raw;
  logic       rd_strobe;

  logic [3:0] lvl_s, evt_s, ovr_s, pb_s;
  logic [3:0] lvl_l, evt_l, ovr_l, pb_l;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic       rd;
    logic [3:0] lvl;
    logic [3:0] evt;
    logic [3:0] ovr;
  } vec_t;

  vec_t tbl[$];

  pushbutton_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .STICKY(1)
  ) dut_s (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .rd_strobe(rd_strobe),
    .btn_level(lvl_s), .btn_event(evt_s), .overrun(ovr_s), .pushbuttons(pb_s)
  );

  pushbutton_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .STICKY(0)
  ) dut_l (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .rd_strobe(rd_strobe),
    .btn_level(lvl_l), .btn_event(evt_l), .overrun(ovr_l), .pushbuttons(pb_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic [3:0] raw, input logic rd,
                     input logic [3:0] lvl, input logic [3:0] evt, input logic [3:0] ovr);
    vec_t v;
    v.rst = rst; v.raw = raw; v.rd = rd; v.lvl = lvl; v.evt = evt; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  task automatic add_n(input int n, input logic rst, input logic [3:0] raw, input logic rd,
                       input logic [3:0] lvl, input logic [3:0] evt, input logic [3:0] ovr);
    for (int k = 0; k < n; k++) add(rst, raw, rd, lvl, evt, ovr);
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then check all outputs of both instances.
  task automatic apply(input int idx, input vec_t v);
    reset     = v.rst;
    btn_raw   = v.raw;
    rd_strobe = v.rd;
    @(posedge clock);
    #1;
    n_vec++;
    cmp("level_s",   idx, lvl_s, v.lvl);
    cmp("event_s",   idx, evt_s, v.evt);
    cmp("overrun_s", idx, ovr_s, v.ovr);
    cmp("pb_sticky", idx, pb_s,  v.evt);
    cmp("level_l",   idx, lvl_l, v.lvl);
    cmp("pb_level",  idx, pb_l,  v.lvl);
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; btn_raw = 4'h0; rd_strobe = 1'b0;

    // 1. reset held with all buttons pressed, then qualification after release
    add_n(3, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0);
    add_n(5, 0, 4'hF, 0, 4'h0, 4'h0, 4'h0);
    add  (   0, 4'hF, 0, 4'hF, 4'hF, 4'h0);
    add  (   0, 4'hF, 1, 4'hF, 4'h0, 4'h0);
    // 2. clean press on bit 0, read at edge 10
    add  (   1, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    add_n(5, 0, 4'h1, 0, 4'h0, 4'h0, 4'h0);
    add  (   0, 4'h1, 0, 4'h1, 4'h1, 4'h0);
    add_n(3, 0, 4'h1, 0, 4'h1, 4'h1, 4'h0);
    add  (   0, 4'h1, 1, 4'h1, 4'h0, 4'h0);
    add  (   0, 4'h1, 0, 4'h1, 4'h0, 4'h0);
    // 3. bounce on bit 1: 1,1,0,0,1,1,0,0 then hold 1
    add_n(2, 0, 4'h3, 0, 4'h1, 4'h0, 4'h0);
    add_n(2, 0, 4'h1, 0, 4'h1, 4'h0, 4'h0);
    add_n(2, 0, 4'h3, 0, 4'h1, 4'h0, 4'h0);
    add_n(2, 0, 4'h1, 0, 4'h1, 4'h0, 4'h0);
    add_n(5, 0, 4'h3, 0, 4'h1, 4'h0, 4'h0);
    add  (   0, 4'h3, 0, 4'h3, 4'h2, 4'h0);
    // 4. bit 2: press, release, press again with the rise landing on a read
    add_n(5, 0, 4'h7, 0, 4'h3, 4'h2, 4'h0);
    add  (   0, 4'h7, 0, 4'h7, 4'h6, 4'h0);
    add_n(5, 0, 4'h3, 0, 4'h7, 4'h6, 4'h0);
    add  (   0, 4'h3, 0, 4'h3, 4'h6, 4'h0);
    add_n(5, 0, 4'h7, 0, 4'h3, 4'h6, 4'h0);
    add  (   0, 4'h7, 1, 4'h7, 4'h4, 4'h0);
    add  (   0, 4'h7, 0, 4'h7, 4'h4, 4'h0);
    // 5. two unread presses on bit 3 -> overrun, one read clears both
    add_n(5, 0, 4'hF, 0, 4'h7, 4'h4, 4'h0);
    add  (   0, 4'hF, 0, 4'hF, 4'hC, 4'h0);
    add_n(5, 0, 4'h7, 0, 4'hF, 4'hC, 4'h0);
    add  (   0, 4'h7, 0, 4'h7, 4'hC, 4'h0);
    add_n(5, 0, 4'hF, 0, 4'h7, 4'hC, 4'h0);
    add  (   0, 4'hF, 0, 4'hF, 4'hC, 4'h8);
    add  (   0, 4'hF, 0, 4'hF, 4'hC, 4'h8);
    add  (   0, 4'hF, 1, 4'hF, 4'h0, 4'h0);
    // 6. reset with counter at 2, button held through it re-qualifies
    add  (   1, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    add_n(4, 0, 4'h1, 0, 4'h0, 4'h0, 4'h0);
    add  (   1, 4'h1, 0, 4'h0, 4'h0, 4'h0);
    add_n(5, 0, 4'h1, 0, 4'h0, 4'h0, 4'h0);
    add  (   0, 4'h1, 0, 4'h1, 4'h1, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(i, tbl[i]);
    end

    // Long read: a rise during a multi-cycle rd_strobe still sets the event,
    // which the continuing strobe then clears.
    v.rst = 1; v.raw = 4'h0; v.rd = 0; v.lvl = 4'h0; v.evt = 4'h0; v.ovr = 4'h0;
    apply(1000, v);
    v.rst = 0; v.raw = 4'h2; v.rd = 1;
    for (int k = 0; k < 5; k++) apply(1001 + k, v);
    v.lvl = 4'h2; v.evt = 4'h2;
    apply(1006, v);
    v.evt = 4'h0;
    apply(1007, v);
    v.rd = 0;
    apply(1008, v);

    // Falling edge after release generates no event
    v.raw = 4'h0;
    for (int k = 0; k < 5; k++) apply(1009 + k, v);
    v.lvl = 4'h0;
    apply(1014, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
